// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: dbg has strict priority,
// and mem/alu share the port round-robin. It also keeps a saturating count of denied requests.
module regfile_wb_arbiter #(
    parameter int          XLEN       = 64,
    parameter int          REG_ADDR_W = 5,
    parameter int          CNT_W      = 16,
    parameter int unsigned DBG_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic [REG_ADDR_W-1:0] dbg_rd,
    input  logic [XLEN-1:0]       dbg_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [XLEN-1:0]       WriteData,
    output logic [CNT_W-1:0]      deny_cnt
);

    typedef enum logic [1:0] {GNT_NONE, GNT_DBG, GNT_MEM, GNT_ALU} grant_e;
    typedef enum logic {RR_ALU, RR_MEM} rr_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rr_e                   rr_q, rr_d;
    grant_e                grant;
    logic                  dbg_req;
    logic                  same_rd;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [2:0]            req_vec;
    logic [2:0]            rdy_vec;
    logic [2:0]            deny_vec;
    logic [1:0]            deny_inc;
    logic [CNT_W+1:0]      cnt_sum;

    always_comb begin
        dbg_req = (DBG_EN != 0) && dbg_valid;
        // Equal nonzero rd means mem is the older instruction, so it must land first.
        same_rd = (mem_rd == alu_rd) && (mem_rd != '0);
    end

    always_comb begin
        grant = GNT_NONE;
        if (!rst_n) begin
            grant = GNT_NONE;
        end else if (dbg_req) begin
            grant = GNT_DBG;
        end else if (mem_valid && alu_valid) begin
            grant = (same_rd || rr_q == RR_MEM) ? GNT_MEM : GNT_ALU;
        end else if (mem_valid) begin
            grant = GNT_MEM;
        end else if (alu_valid) begin
            grant = GNT_ALU;
        end
    end

    assign dbg_ready = (grant == GNT_DBG);
    assign mem_ready = (grant == GNT_MEM);
    assign alu_ready = (grant == GNT_ALU);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (grant)
            GNT_DBG: begin
                sel_rd   = dbg_rd;
                sel_data = dbg_data;
            end
            GNT_MEM: begin
                sel_rd   = mem_rd;
                sel_data = mem_data;
            end
            GNT_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase
    end

    // Round-robin pointer: dbg grants leave it alone.
    always_comb begin
        rr_d = rr_q;
        case (grant)
            GNT_MEM: rr_d = RR_ALU;
            GNT_ALU: rr_d = RR_MEM;
            default: rr_d = rr_q;
        endcase
    end

    // Writes to x0 are consumed but never reach the register file; the address and data hold.
    always_comb begin
        regwrite_d = (grant != GNT_NONE) && (sel_rd != '0);
        wreg_d     = regwrite_d ? sel_rd : wreg_q;
        wdata_d    = regwrite_d ? sel_data : wdata_q;
    end

    assign req_vec = {dbg_req, mem_valid, alu_valid};
    assign rdy_vec = {dbg_ready, mem_ready, alu_ready};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deny
            assign deny_vec[gi] = req_vec[gi] & ~rdy_vec[gi];
        end
    endgenerate

    always_comb begin
        deny_inc = {1'b0, deny_vec[0]} + {1'b0, deny_vec[1]} + {1'b0, deny_vec[2]};
        cnt_sum  = (CNT_W+2)'(cnt_q) + (CNT_W+2)'(deny_inc);
        cnt_d    = (cnt_sum > (CNT_W+2)'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= RR_ALU;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign WriteReg  = wreg_q;
    assign WriteData = wdata_q;
    assign deny_cnt  = cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between three writeback requesters: debug/config (dbg), memory/load (mem) and ALU (alu). It arbitrates each cycle, drops writes to x0, and drives a registered RegWrite/WriteReg/WriteData triple directly into RegisterFile. It sits between the execute/memory writeback paths and RegisterFile. It also exports a saturating count of denied requests for performance monitoring.

Parameters:
XLEN, 64, data width of the write port
REG_ADDR_W, 5, register index width (32 registers)
CNT_W, 16, width of the denial counter
DBG_EN, 1, 1 enables the dbg requester; 0 ties dbg_ready low and ignores dbg_valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
dbg_valid  in  1  debug write request
dbg_ready  out  1  debug request accepted this cycle
dbg_rd  in  REG_ADDR_W  debug destination register
dbg_data  in  XLEN  debug write data
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_rd  in  REG_ADDR_W  load destination register
mem_data  in  XLEN  load write data
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  REG_ADDR_W  ALU destination register
alu_data  in  XLEN  ALU write data
RegWrite  out  1  write enable to RegisterFile
WriteReg  out  REG_ADDR_W  write index to RegisterFile
WriteData  out  XLEN  write data to RegisterFile
deny_cnt  out  CNT_W  saturating count of requester-cycles with valid=1 and ready=0

Behaviour:
- Reset (rst_n=0, asynchronous): RegWrite=0, WriteReg=0, WriteData=0, deny_cnt=0, RR pointer=ALU. All readies are 0 while rst_n=0.
- Handshake: a transfer occurs when valid&&ready. Ready is combinational from the valids and the RR pointer, so requesters must not derive valid from ready. At most one ready is high per cycle. A requester holds valid, rd and data stable until ready.
- Priority: dbg is strict highest. If dbg is not valid, mem and alu share the port round-robin.
- RR rule: if only one of mem/alu is valid, it is granted. If both are valid, the side named by the pointer is granted. After any mem or alu grant, the pointer moves to the other side. dbg grants leave the pointer unchanged.
- Same-rd override: if mem and alu are both valid with equal nonzero rd, mem (the older instruction) is granted regardless of the pointer, and the pointer then moves to ALU.
- Latency: a transfer at edge N gives RegWrite=1, WriteReg=rd and WriteData=data during cycle N..N+1. RegisterFile commits at edge N+1. Throughput is one write per cycle; the output stage never stalls.
- x0: an accepted request with rd=0 is consumed normally (ready=1). Next cycle RegWrite=0, and WriteReg/WriteData hold their previous values.
- No grant in a cycle gives RegWrite=0 next cycle, with WriteReg/WriteData held.
- deny_cnt increments by the number of requesters (0-2) with valid=1 and ready=0 in that cycle. It saturates at 2^CNT_W-1 and never wraps.
- DBG_EN=0: dbg_valid is ignored, dbg_ready=0, and dbg is never counted as denied.
- Reset asserted mid-stream: outputs clear immediately. Any request presented in that cycle is not accepted, and the requester retries after reset.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, all valids 0 -> RegWrite=0, WriteReg=0, WriteData=0, deny_cnt=0, all readies 0.
- Single ALU write: alu_valid=1, rd=1, data=64'hAAAA_AAAA_AAAA_AAAA for 1 cycle -> alu_ready=1 that cycle; next cycle RegWrite=1, WriteReg=1, data matches; RegisterFile x1 reads AAAA.. afterwards.
- RR contention: mem (rd=2, 64'h5555_5555_5555_5555) and alu (rd=3, 64'h1234_5678_9ABC_DEF0) held valid from reset -> alu granted first, mem second, on consecutive cycles; deny_cnt=1.
- dbg priority: dbg rd=31, data=64'hFFFF_0000_FFFF_0000 together with mem and alu valid -> dbg granted first, then alu, then mem; RR pointer unchanged by dbg; deny_cnt=2+1=3.
- x0 drop: alu rd=0, data=64'hFFFF_FFFF_FFFF_FFFF -> alu_ready=1, RegWrite stays 0, x0 reads 0.
- Same-rd and saturation: mem and alu both rd=5 with pointer=ALU -> mem granted first; with CNT_W=2, forcing 5 denials -> deny_cnt holds at 3.
